// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   state_e    : arbiter FSM states (drain, idle, issue, wait)
//   port_idx_t : requester index, PORT_FETCH = instruction fetch, PORT_DATA = data
//   DRAIN_CYC  : cycles spent in drain after reset or an aborted access
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    StDrain,
    StIdle,
    StIssue,
    StWait
  } state_e;

  typedef logic port_idx_t;

  localparam port_idx_t   PORT_FETCH = 1'b0;
  localparam port_idx_t   PORT_DATA  = 1'b1;
  localparam int unsigned DRAIN_CYC  = 2;

  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the memory arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives completions/enables)
//   master : environment view (requesters plus memory)
// Requester signals are indexed [1:0] per port; memory signals are single-channel.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DW     = 8
) ();

  logic [1:0]             p_req;
  logic [1:0]             p_we;
  logic [1:0][ADDR_W-1:0] p_addr;
  logic [1:0][DW-1:0]     p_wdata;
  logic [1:0]             p_done;
  logic [DW-1:0]          p_rdata;
  logic                   p_err;

  logic                   mem_write_en;
  logic                   mem_read_en;
  logic [ADDR_W-1:0]      mem_write_addr;
  logic [ADDR_W-1:0]      mem_read_addr;
  logic [DW-1:0]          mem_write_data;
  logic                   mem_ready;
  logic [DW-1:0]          mem_read_data;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, mem_ready, mem_read_data,
    output p_done, p_rdata, p_err,
    output mem_write_en, mem_read_en, mem_write_addr, mem_read_addr, mem_write_data
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, mem_ready, mem_read_data,
    input  p_done, p_rdata, p_err,
    input  mem_write_en, mem_read_en, mem_write_addr, mem_read_addr, mem_write_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with its priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> PORT_FETCH)
//   req_i      : request vector, bit n = port n
//   update_i   : commit the current pick; pointer then favours the other port
//   valid_o    : any request present
//   idx_o      : picked port
module rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       valid_o,
  output port_idx_t  idx_o
);

  port_idx_t ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    idx_o   = ptr_q;
    case (req_i)
      2'b01:   idx_o = PORT_FETCH;
      2'b10:   idx_o = PORT_DATA;
      default: idx_o = ptr_q;  // collision: pointer decides
    endcase
    ptr_d = ptr_q;
    if (update_i && valid_o) begin
      ptr_d = other_port(idx_o);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_FETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-channel synchronous memory.
// A granted request is latched, issued as a one-cycle read or write enable, and
// completed with a one-cycle p_done pulse on the first mem_ready seen in WAIT.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (requester and memory signals)
// Build option: define MEM_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles
// without mem_ready (p_done with p_err=1, then DRAIN). Without it p_err is tied 0.
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DW          = 8,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  port_idx_t         gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [1:0]        done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  logic [1:0]        arb_req;
  logic              arb_valid;
  logic              arb_update;
  port_idx_t         arb_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // A port still seeing its own p_done has not yet dropped its request.
  assign arb_req = bus.p_req & ~done_q;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (arb_req),
    .update_i (arb_update),
    .valid_o  (arb_valid),
    .idx_o    (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = '0;
    rdata_d     = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    arb_update  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      StDrain: begin
        if (drain_cnt_q == DrainW'(DRAIN_CYC - 1)) begin
          drain_cnt_d = '0;
          state_d     = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          gnt_d      = arb_idx;
          we_d       = bus.p_we[arb_idx];
          addr_d     = bus.p_addr[arb_idx];
          wdata_d    = bus.p_wdata[arb_idx];
          // Enables are registered here so they are high exactly during ISSUE.
          mem_we_d   = bus.p_we[arb_idx];
          mem_re_d   = ~bus.p_we[arb_idx];
          state_d    = StIssue;
        end
      end
      StIssue: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (bus.mem_ready) begin
          done_d[gnt_q] = 1'b1;
          rdata_d       = we_q ? '0 : bus.mem_read_data;
          state_d       = StIdle;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
          done_d[gnt_q] = 1'b1;
          err_d         = 1'b1;
          drain_cnt_d   = '0;
          state_d       = StDrain;  // absorb a late mem_ready
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StDrain;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDrain;
      drain_cnt_q <= '0;
      gnt_q       <= PORT_FETCH;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign bus.p_err = err_q;
`else
  assign bus.p_err = 1'b0;
`endif

  assign bus.p_done         = done_q;
  assign bus.p_rdata        = rdata_q;
  assign bus.mem_write_en   = mem_we_q;
  assign bus.mem_read_en    = mem_re_q;
  assign bus.mem_write_addr = addr_q;
  assign bus.mem_read_addr  = addr_q;
  assign bus.mem_write_data = wdata_q;

endmodule
